// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl_pkg
//  Description : Shared definitions for the bit-serial adder controller:
//                FSM state encoding (fixed 2-bit) and the default operand
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_add_ctrl_pkg;

    localparam int c_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl_if
//  Description : Request/result bundle of the bit-serial adder controller.
//                master : start, op_a, op_b, cin, sub     (drives requests)
//                slave  : busy, done, sum, cout, ovf      (drives results)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_ctrl_pkg::c_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op_a, op_b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_a, op_b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fa_cell
//  Description : Combinational 1-bit full adder used as the serial datapath.
//                Ports: a, b, ci (inputs) -> s (sum), co (carry out).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder controller. One operand bit pair per clock
//                is summed LSB first through a single full-adder cell; the
//                result, carry out and signed overflow are published when the
//                last bit completes, together with a one-cycle done pulse.
//                Ports : clk, rst (sync, active-high),
//                        bus (serial_add_ctrl_if.slave: start, op_a, op_b,
//                        cin, sub in; busy, done, sum, cout, ovf out).
//                Macro : SERIAL_SUB_EN - when defined, sub=1 computes op_a-op_b
//                        (B inverted at load, carry forced to 1, cin ignored).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_acc;      // upper partial-sum bits collected so far
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

`ifdef SERIAL_SUB_EN
    // Two's-complement subtraction: A + ~B + 1.
    assign w_b_load = bus.sub ? ~bus.op_b : bus.op_b;
    assign w_c_load = bus.sub | bus.cin;
`else
    logic w_unused_sub;
    assign w_b_load     = bus.op_b;
    assign w_c_load     = bus.cin;
    assign w_unused_sub = bus.sub;
`endif

    serial_fa_cell u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    assign w_acc_next = {w_s, r_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.op_a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_acc   <= w_acc_next[WIDTH-1:1];
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_co;
                        // r_carry here is the carry into the MSB position.
                        r_ovf   <= w_co ^ r_carry;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl (WIDTH=8). Expected
//                results are queued at issue time from an arithmetic model and
//                popped by a monitor on every done pulse. Honours
//                SERIAL_SUB_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;
    localparam int W = 8;
`ifdef SERIAL_SUB_EN
    localparam bit c_SUB = 1'b1;
`else
    localparam bit c_SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           checks    = 0;
    int           failures  = 0;
    int           done_seen = 0;
    logic         prev_done = 1'b0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result as {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic s);
        int   sa = $signed(a);
        int   sb = $signed(b);
        int   u;
        int   r;
        logic co;
        logic ov;
        logic [W-1:0] res;
        if (c_SUB && s) begin
            u  = int'(a) - int'(b);
            r  = sa - sb;
            co = (int'(a) >= int'(b));
        end else begin
            u  = int'(a) + int'(b) + int'(ci);
            r  = sa + sb + int'(ci);
            co = (u >= (1 << W));
        end
        ov  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
        res = u[W-1:0];
        return {ov, co, res};
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_seen++;
            check("done_pulse_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got sum=0x%0h with no result expected", bus.sum);
            end else begin
                exp_v = exp_q.pop_front();
                check("result_ovf_cout_sum", {22'd0, bus.ovf, bus.cout, bus.sum}, {22'd0, exp_v});
            end
        end
        prev_done = bus.done;
    end

    task automatic randomize_ops();
        bus.op_a = W'($urandom);
        bus.op_b = W'($urandom);
        bus.cin  = 1'($urandom);
        bus.sub  = 1'($urandom);
    endtask

    // Issues one operation from IDLE and follows it back to IDLE.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = ci;
        bus.sub   = s;
        exp_q.push_back(model(a, b, ci, s));
        @(posedge clk);
        #1;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        // Noise on start and operands while busy must not be captured.
        lat = 0;
        for (int i = 1; i <= W + 4; i++) begin
            bus.start = 1'($urandom);
            randomize_ops();
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        check("latency_edges", lat, W);
        if (lat == 0) exp_q.delete();
        check("busy_in_done", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        check("busy_back_idle", {31'd0, bus.busy}, 32'd0);
        check("done_low_after", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_sum",  {24'd0, bus.sum},  32'd0);
        check("reset_cout", {31'd0, bus.cout}, 32'd0);
        check("reset_ovf",  {31'd0, bus.ovf},  32'd0);

        // Directed corner vectors.
        issue(8'h35, 8'h4A, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        issue(8'h80, 8'h80, 1'b1, 1'b0);
        issue(8'h10, 8'h01, 1'b0, 1'b1);
        issue(8'h00, 8'h01, 1'b1, 1'b1);

        // start held for 30 cycles: accepted every W+2 edges, operands
        // scrambled on every other edge.
        @(negedge clk);
        base      = done_seen;
        bus.start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c % (W + 2) == 0) begin
                bus.op_a = 8'h01;
                bus.op_b = 8'h01;
                bus.cin  = 1'b0;
                bus.sub  = 1'b0;
                exp_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
            end
            @(posedge clk);
            #1;
            randomize_ops();
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("continuous_done_count", done_seen - base, 3);

        // Reset during the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 8'h12;
        bus.op_b  = 8'h34;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        base = done_seen;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_sum",  {24'd0, bus.sum},  32'd0);
        check("abort_cout", {31'd0, bus.cout}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (W + 4) @(negedge clk);
        check("abort_no_done", done_seen - base, 0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_over_start_busy", {31'd0, bus.busy}, 32'd0);

        issue(8'h35, 8'h4A, 1'b0, 1'b0);

        // Randomised operations with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 Port clk, input, 1, single rising-edge clock.
REQ-003 Port rst, input, 1, synchronous, active-high reset.
REQ-004 Port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 Port op_a, input, WIDTH, operand A, captured on accepted start.
REQ-006 Port op_b, input, WIDTH, operand B, captured on accepted start.
REQ-007 Port cin, input, 1, carry-in, captured on accepted start.
REQ-008 Port sub, input, 1, subtract select, captured on accepted start (effective only with SERIAL_SUB_EN).
REQ-009 Port busy, output, 1, high while operation in progress.
REQ-010 Port done, output, 1, single-cycle completion pulse.
REQ-011 Port sum, output, WIDTH, result register.
REQ-012 Port cout, output, 1, final carry out.
REQ-013 Port ovf, output, 1, signed overflow of final result.

Function
REQ-014 States: IDLE, SHIFT, DONE; encoding fixed 2-bit.
REQ-015 IDLE: start=1 -> load A/B shift registers, carry flop <= cin, bit counter <= 0, go SHIFT; start=0 -> stay.
REQ-016 SHIFT: each cycle, one full-adder evaluation on A[0], B[0], carry flop; sum bit shifted into sum MSB, A/B shifted right, carry flop <= adder carry, counter++.
REQ-017 SHIFT -> DONE after exactly WIDTH SHIFT cycles (counter reaches WIDTH-1 on the last).
REQ-018 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 Latency: start sampled at edge k -> done high in cycle k+WIDTH+1; next start accepted in that same DONE cycle's following IDLE cycle (minimum issue interval WIDTH+2).
REQ-020 busy=1 in SHIFT and DONE, 0 in IDLE.
REQ-021 start while busy ignored; op inputs not re-captured.
REQ-022 sum, cout, ovf update only at the SHIFT->DONE transition and hold until next completion.
REQ-023 ovf = carry into MSB XOR carry out of MSB.
REQ-024 Arithmetic modulo 2^WIDTH; cout is bit WIDTH of A+B+cin.

Reset
REQ-025 rst=1 at any edge: state <= IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry flop=0, counter=0.
REQ-026 rst mid-SHIFT aborts; no done pulse; result registers cleared.
REQ-027 rst overrides simultaneous start.

Configuration
REQ-028 Macro SERIAL_SUB_EN defined: sub=1 inverts B bits into adder and forces carry flop <= 1 at load (cin ignored), giving A-B; cout=1 means no borrow.
REQ-029 SERIAL_SUB_EN undefined: sub ignored, block adds only; no inversion logic present.

Structure
REQ-030 Shared package holds state encodings (ST_IDLE=0, ST_SHIFT=1, ST_DONE=2) and WIDTH default constant.
REQ-031 One sub-module serial_fa_cell: combinational 1-bit full adder (s, co from a, b, ci), instantiated once.
REQ-032 Gate/propagation delays confined to serial_fa_cell; controller logic zero-delay registered.

Verification
REQ-033 WIDTH=8, A=0x35, B=0x4A, cin=0, start one cycle -> done in cycle 9 after start, sum=0x7F, cout=0, ovf=0.
REQ-034 A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; A=0x7F, B=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-035 start held high continuously for 30 cycles, A=0x01, B=0x01 -> done pulses every 10 cycles, each sum=0x02; op changes mid-op have no effect.
REQ-036 rst asserted at 4th SHIFT cycle -> next cycle busy=0, sum=0, no done pulse; subsequent start completes normally.
REQ-037 SERIAL_SUB_EN defined, sub=1, A=0x10, B=0x01 -> sum=0x0F, cout=1; A=0x00, B=0x01 -> sum=0xFF, cout=0; undefined build with sub=1 -> sum=0x11.
